// File: rtl/imem_loader.sv
// Program loader: takes 32-bit instruction words from a valid/ready stream and
// writes each into the byte-wide instruction memory as four big-endian byte writes.
module imem_loader #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-2:0] num_words,
  input  logic              word_valid,
  input  logic [31:0]       word_data,
  output logic              word_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CW    = ADDR_W - 1;
  localparam int LIMIT = (MEM_BYTES - BASE_ADDR) / 4;
  localparam logic [ADDR_W-1:0] BASE_V = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_WR0,
    S_WR1,
    S_WR2,
    S_WR3,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]     total, total_n;
  logic [CW-1:0]     count, count_n;
  logic [ADDR_W-1:0] wp, wp_n;
  logic [31:0]       word, word_n;

  logic              busy_n, done_n, error_n;
  logic              ready_n, we_n;
  logic [ADDR_W-1:0] addr_n;
  logic [7:0]        wdata_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Outputs are computed from the next state so that every port is a flop.
  always_comb begin
    state_n = state;
    total_n = total;
    count_n = count;
    wp_n    = wp;
    word_n  = word;
    busy_n  = busy;
    done_n  = done;
    error_n = error;
    ready_n = 1'b0;
    we_n    = 1'b0;
    addr_n  = '0;
    wdata_n = '0;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (int'(num_words) > LIMIT) begin
            error_n = 1'b1;
            done_n  = 1'b0;
            busy_n  = 1'b0;
            state_n = S_IDLE;
          end else if (num_words == '0) begin
            error_n = 1'b0;
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = S_DONE;
          end else begin
            error_n = 1'b0;
            done_n  = 1'b0;
            busy_n  = 1'b1;
            total_n = num_words;
            wp_n    = BASE_V;
            count_n = '0;
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (word_valid && word_ready) begin
          word_n  = word_data;
          state_n = S_WR0;
        end
      end
      S_WR0: state_n = S_WR1;
      S_WR1: state_n = S_WR2;
      S_WR2: state_n = S_WR3;
      S_WR3: begin
        wp_n    = wp + ADDR_W'(4);
        count_n = count + CW'(1);
        if (count_n == total) begin
          state_n = S_DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          state_n = S_WAIT;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // The LIMIT check at start guarantees wp + 3 never wraps.
    case (state_n)
      S_WAIT: ready_n = 1'b1;
      S_WR0: begin
        we_n    = 1'b1;
        addr_n  = wp_n;
        wdata_n = word_n[31:24];
      end
      S_WR1: begin
        we_n    = 1'b1;
        addr_n  = wp_n + ADDR_W'(1);
        wdata_n = word_n[23:16];
      end
      S_WR2: begin
        we_n    = 1'b1;
        addr_n  = wp_n + ADDR_W'(2);
        wdata_n = word_n[15:8];
      end
      S_WR3: begin
        we_n    = 1'b1;
        addr_n  = wp_n + ADDR_W'(3);
        wdata_n = word_n[7:0];
      end
      default: begin
        ready_n = 1'b0;
        we_n    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total      <= '0;
      count      <= '0;
      wp         <= '0;
      word       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      total      <= total_n;
      count      <= count_n;
      wp         <= wp_n;
      word       <= word_n;
      busy       <= busy_n;
      done       <= done_n;
      error      <= error_n;
      word_ready <= ready_n;
      mem_we     <= we_n;
      mem_addr   <= addr_n;
      mem_wdata  <= wdata_n;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: drives random program loads and compares the byte
// writes and resulting memory image against a word-level reference model.
module tb_imem_loader;

  localparam int MEM_BYTES = 1024;
  localparam int ADDR_W    = 10;
  localparam int BASE_ADDR = 0;
  localparam int NW        = ADDR_W - 1;
  localparam int LIMIT     = (MEM_BYTES - BASE_ADDR) / 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [NW-1:0]     num_words;
  logic              word_valid;
  logic [31:0]       word_data;
  logic              word_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              busy;
  logic              done;
  logic              error;

  logic [7:0]        imem    [MEM_BYTES];
  logic [7:0]        ref_mem [MEM_BYTES];
  logic [ADDR_W+7:0] obs_q [$];
  logic [ADDR_W+7:0] exp_q [$];
  logic [31:0]       src_q [$];

  int checks   = 0;
  int failures = 0;
  int idle_bad = 0;

  imem_loader #(
    .MEM_BYTES(MEM_BYTES),
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE_ADDR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_words (num_words),
    .word_valid(word_valid),
    .word_data (word_data),
    .word_ready(word_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Bench-side I-memory: a strobe seen mid-cycle commits that byte.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      imem[mem_addr] = mem_wdata;
      obs_q.push_back({mem_addr, mem_wdata});
    end else if (mem_addr !== '0 || mem_wdata !== '0) begin
      idle_bad++;
    end
  end

  task automatic do_start(input int n);
    @(negedge clk);
    start     = 1'b1;
    num_words = NW'(n);
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic model_word(input int idx, input logic [31:0] w);
    int                a;
    logic [31:0]       sh;
    logic [ADDR_W-1:0] av;
    for (int k = 0; k < 4; k++) begin
      a  = BASE_ADDR + 4 * idx + k;
      sh = w >> (24 - 8 * k);
      av = ADDR_W'(a);
      exp_q.push_back({av, sh[7:0]});
      ref_mem[a] = sh[7:0];
    end
  endtask

  task automatic compare_writes(input string name);
    int bad;
    int lim;
    bad = 0;
    lim = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("[TB] FAIL %s_write_count got=%0d expected=%0d", name, obs_q.size(), exp_q.size());
    end
    for (int j = 0; j < lim; j++) if (obs_q[j] !== exp_q[j]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("[TB] FAIL %s_write_seq got=%0d bad entries expected=0", name, bad);
    end
    bad = 0;
    for (int a = 0; a < MEM_BYTES; a++) if (imem[a] !== ref_mem[a]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("[TB] FAIL %s_mem_image got=%0d bad bytes expected=0", name, bad);
    end
  endtask

  // Loads src_q; optional random valid gaps, optional stray start after word 0.
  task automatic run_load(input string name, input bit gaps, input bit inject);
    int          n;
    int          budget;
    logic [31:0] w;
    n = src_q.size();
    obs_q.delete();
    exp_q.delete();
    do_start(n);
    checks++;
    if (busy !== 1'b1 || word_ready !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s_start got busy=%b ready=%b done=%b error=%b expected 1 1 0 0",
               name, busy, word_ready, done, error);
    end
    for (int i = 0; i < n; i++) begin
      w = src_q[i];
      model_word(i, w);
      if (gaps) begin
        word_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      word_data  = w;
      word_valid = 1'b1;
      budget     = 0;
      while (word_ready !== 1'b1 && budget < 20) begin
        @(negedge clk);
        budget++;
      end
      if (budget >= 20) begin
        checks++;
        failures++;
        $display("[TB] FAIL %s_ready_timeout got ready=%b expected 1 within 20 cycles", name, word_ready);
        word_valid = 1'b0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
      if (inject && i == 0) begin
        start     = 1'b1;
        num_words = NW'(5);
        @(negedge clk);
        start     = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
          failures++;
          $display("[TB] FAIL %s_ignored_start got busy=%b done=%b error=%b expected 1 0 0",
                   name, busy, done, error);
        end
      end
      if (i == n - 1) begin
        word_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || mem_we !== 1'b1) begin
          failures++;
          $display("[TB] FAIL %s_last_wr3 got done=%b busy=%b we=%b expected 0 1 1",
                   name, done, busy, mem_we);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || word_ready !== 1'b0 || mem_we !== 1'b0) begin
          failures++;
          $display("[TB] FAIL %s_done got done=%b busy=%b ready=%b we=%b expected 1 0 0 0",
                   name, done, busy, word_ready, mem_we);
        end
      end
    end
    compare_writes(name);
  endtask

  task automatic test_reset;
    start      = 1'b0;
    num_words  = '0;
    word_valid = 1'b0;
    word_data  = '0;
    rst_n      = 1'b1;
    #1 rst_n   = 1'b0;
    #1;
    checks++;
    if ({word_ready, mem_we, mem_addr, mem_wdata, busy, done, error} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got ready=%b we=%b addr=%0d wdata=%h busy=%b done=%b error=%b expected all 0",
               word_ready, mem_we, mem_addr, mem_wdata, busy, done, error);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_two_word;
    logic [31:0] fetched;
    src_q = '{32'h8C080004, 32'h01095020};
    run_load("two_word", 1'b0, 1'b0);
    fetched = {imem[4], imem[5], imem[6], imem[7]};
    checks++;
    if (fetched !== 32'h01095020) begin
      failures++;
      $display("[TB] FAIL two_word_fetch_pc4 got=%h expected=01095020", fetched);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] w;
    int          budget;
    w = $urandom;
    obs_q.delete();
    exp_q.delete();
    model_word(0, w);
    word_valid = 1'b0;
    do_start(1);
    for (int c = 0; c < 3; c++) begin
      if (c != 0) @(negedge clk);
      checks++;
      if (word_ready !== 1'b1 || mem_we !== 1'b0) begin
        failures++;
        $display("[TB] FAIL backpressure_hold%0d got ready=%b we=%b expected 1 0", c, word_ready, mem_we);
      end
    end
    word_data  = w;
    word_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    word_valid = 1'b0;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== ADDR_W'(BASE_ADDR) || mem_wdata !== w[31:24]) begin
      failures++;
      $display("[TB] FAIL backpressure_accept got we=%b addr=%0d wdata=%h expected 1 %0d %h",
               mem_we, mem_addr, mem_wdata, BASE_ADDR, w[31:24]);
    end
    budget = 0;
    while (done !== 1'b1 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (budget != 4) begin
      failures++;
      $display("[TB] FAIL backpressure_done_latency got=%0d expected=4 extra cycles", budget);
    end
    compare_writes("backpressure");
  endtask

  task automatic test_random_loads;
    int n;
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 6);
      src_q.delete();
      for (int i = 0; i < n; i++) src_q.push_back($urandom);
      run_load($sformatf("random%0d", r), 1'b1, 1'b0);
    end
  endtask

  task automatic test_over_limit;
    int n;
    for (int r = 0; r < 2; r++) begin
      n = (r == 0) ? LIMIT + 1 : $urandom_range(LIMIT + 2, (1 << NW) - 1);
      obs_q.delete();
      do_start(n);
      checks++;
      if (error !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || word_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL over_limit_%0d got error=%b done=%b busy=%b ready=%b expected 1 0 0 0",
                 n, error, done, busy, word_ready);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (obs_q.size() != 0 || error !== 1'b1) begin
        failures++;
        $display("[TB] FAIL over_limit_%0d_hold got writes=%0d error=%b expected 0 1", n, obs_q.size(), error);
      end
    end
  endtask

  task automatic test_zero_words;
    obs_q.delete();
    do_start(0);
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0 || word_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL zero_words got done=%b error=%b busy=%b ready=%b expected 1 0 0 0",
               done, error, busy, word_ready);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (obs_q.size() != 0 || done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL zero_words_hold got writes=%0d done=%b expected 0 1", obs_q.size(), done);
    end
  endtask

  task automatic test_full;
    logic [ADDR_W+7:0] last;
    src_q.delete();
    for (int i = 0; i < LIMIT; i++) src_q.push_back($urandom);
    run_load("full", 1'b0, 1'b0);
    last = (obs_q.size() > 0) ? obs_q[obs_q.size() - 1] : '0;
    checks++;
    if (obs_q.size() == 0 || last[ADDR_W+7:8] !== ADDR_W'(MEM_BYTES - 1)) begin
      failures++;
      $display("[TB] FAIL full_last_addr got=%0d expected=%0d", last[ADDR_W+7:8], MEM_BYTES - 1);
    end
  endtask

  task automatic test_mid_word_reset;
    logic [31:0] w;
    int          budget;
    w = $urandom;
    obs_q.delete();
    do_start(2);
    word_data  = w;
    word_valid = 1'b1;
    budget     = 0;
    while (word_ready !== 1'b1 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== ADDR_W'(BASE_ADDR + 1)) begin
      failures++;
      $display("[TB] FAIL midreset_in_wr1 got we=%b addr=%0d expected 1 %0d", mem_we, mem_addr, BASE_ADDR + 1);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({word_ready, mem_we, mem_addr, mem_wdata, busy, done, error} !== '0) begin
      failures++;
      $display("[TB] FAIL midreset_async got ready=%b we=%b addr=%0d wdata=%h busy=%b done=%b error=%b expected all 0",
               word_ready, mem_we, mem_addr, mem_wdata, busy, done, error);
    end
    word_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (word_ready !== 1'b0 || busy !== 1'b0 || mem_we !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_idle got ready=%b busy=%b we=%b expected 0 0 0", word_ready, busy, mem_we);
    end
    ref_mem[BASE_ADDR]     = w[31:24];
    ref_mem[BASE_ADDR + 1] = w[23:16];
    checks++;
    if (obs_q.size() != 2 || obs_q[0] !== {ADDR_W'(BASE_ADDR), w[31:24]}
        || obs_q[1] !== {ADDR_W'(BASE_ADDR + 1), w[23:16]}) begin
      failures++;
      $display("[TB] FAIL midreset_partial got writes=%0d expected 2 bytes %h %h", obs_q.size(), w[31:24], w[23:16]);
    end
  endtask

  task automatic test_start_while_busy;
    src_q.delete();
    src_q.push_back($urandom);
    src_q.push_back($urandom);
    run_load("busy_start", 1'b0, 1'b1);
    src_q.delete();
    src_q.push_back($urandom);
    run_load("restart", 1'b1, 1'b0);
  endtask

  task automatic test_idle_outputs;
    checks++;
    if (idle_bad != 0) begin
      failures++;
      $display("[TB] FAIL idle_addr_data got=%0d nonzero cycles expected=0", idle_bad);
    end
  endtask

  initial begin
    for (int a = 0; a < MEM_BYTES; a++) begin
      imem[a]    = 8'h00;
      ref_mem[a] = 8'h00;
    end
    test_reset();
    test_two_word();
    test_backpressure();
    test_random_loads();
    test_over_limit();
    test_zero_words();
    test_full();
    test_mid_word_reset();
    test_start_while_busy();
    test_idle_outputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader for the instruction memory. Accepts 32-bit instruction words over a valid/ready stream and writes each one into the byte-wide instruction memory as four sequential byte writes in big-endian order: MSB at the lowest address, matching how the fetch side reassembles `Instruction`. It sits between the testbench/boot source and the I-memory write port, and replaces `$readmemb` preloading when a program is downloaded at run time.

## Interface
- `MEM_BYTES`, 1024: instruction memory size in bytes.
- `ADDR_W`, 10: byte address width; `2**ADDR_W == MEM_BYTES`.
- `BASE_ADDR`, 0: byte address of the first word. Must be a multiple of 4.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a load; sampled only in IDLE or DONE.
- `num_words`  in  ADDR_W-1  number of words to load; sampled with `start`.
- `word_valid`  in  1  source has a word on `word_data`.
- `word_data`  in  32  instruction word.
- `word_ready`  out  1  loader accepts a word this cycle.
- `mem_we`  out  1  byte write strobe to I-memory.
- `mem_addr`  out  ADDR_W  byte write address.
- `mem_wdata`  out  8  byte write data.
- `busy`  out  1  a load is in progress.
- `done`  out  1  the last load completed; held high.
- `error`  out  1  the last `start` was rejected; held high.

## Operation
- States:
  - IDLE: after reset.
  - WAIT: `word_ready=1`.
  - WR0..WR3: byte writes.
  - DONE.
- Capacity: `LIMIT = (MEM_BYTES-BASE_ADDR)/4`.
- `start` in IDLE or DONE:
  - If `num_words > LIMIT`: set `error=1`, clear `done`, go to IDLE, no writes.
  - If `num_words == 0`: clear `error`, set `done=1`, go to DONE.
  - Otherwise: clear `error` and `done`, set `busy=1`, latch `num_words`, set word pointer `wp=BASE_ADDR`, set count to 0, go to WAIT.
- `start` in any other state is ignored. It does not affect `error` or `done`.
- WAIT: a word is accepted when `word_valid && word_ready`. The loader latches `word_data` and goes to WR0. With no valid, it stays in WAIT indefinitely.
- WRk (k=0..3): `mem_we=1`, `mem_addr=wp+k`, `mem_wdata=word[31-8k:24-8k]`.
- After WR3: `wp+=4`, count+=1.
  - If count equals `num_words`: go to DONE, `busy=0`, `done=1`.
  - Otherwise: go to WAIT.
- Address wrap cannot occur, because the `LIMIT` check guarantees it.
- `mem_addr` and `mem_wdata` read 0 whenever `mem_we=0`.
- `word_ready` is high only in WAIT.
- All outputs are registered.

## Timing
- Reset values: state IDLE; `word_ready`, `mem_we`, `mem_addr`, `mem_wdata`, `busy`, `done`, `error` all 0. Counters are 0.
- Reset takes effect immediately, including mid-word. Writes stop at once. Bytes already written stay in memory, and no partial-word rollback is performed.
- `start` sampled at edge t:
  - `busy` and `word_ready` go high in cycle t+1.
  - `error`, or `done` for `num_words=0`, goes high in cycle t+1.
- Word accepted at edge e: `mem_we=1` in cycles e+1 through e+4, with addresses `wp..wp+3` in order.
- If more words remain, `word_ready` is high again in cycle e+5. Peak throughput is 1 word per 5 cycles.
- On the final word, `done=1` and `busy=0` from cycle e+5.
- `done` and `error` are held until the next accepted `start`.

## Test plan
- Reset: assert `rst_n=0` mid-simulation with stimulus active. All outputs must read 0 asynchronously, before the next clock edge.
- Two-word load, BASE 0:
  - Stimulus: words 0x8C080004 and 0x01095020, `word_valid` held high.
  - Required writes: bytes 8C,08,00,04 at addresses 0..3, then 01,09,50,20 at 4..7. Exactly 8 `mem_we` cycles.
  - `done=1` from 5 cycles after the second accept. A fetch at PC 4 returns 0x01095020.
- Backpressure: after `start`, hold `word_valid=0` for 3 cycles. `word_ready` must stay 1 with no writes. Accept occurs in the first cycle valid is high.
- Boundaries, with MEM_BYTES=1024 and BASE 0:
  - `num_words=0`: `done=1` next cycle, no writes.
  - `num_words=257`: `error=1`, no writes, `busy=0`.
  - `num_words=256`: last write at address 1023.
- Reset mid-word: assert `rst_n=0` in WR1. `mem_we` must drop immediately. After release the state is IDLE and `word_ready=0`. Bytes 0..1 of that word are present in memory.
- Start while busy: pulse `start` with `num_words=5` during a 2-word load. It is ignored: exactly 8 writes occur. A second `start` issued after DONE rewrites from BASE_ADDR and clears `done` the next cycle.
